// File: rtl/mem_wait_ctrl.sv
// Wait-state controller between the CPU MEM stage and an async SRAM: zero-wait fast window,
// RD_WAIT/WR_WAIT stall cycles elsewhere. Define MEM_WAIT_STATS_EN to add stall/access counters.
`timescale 1ns/1ps
module mem_wait_ctrl #(
  parameter int                DATA_W    = 32,
  parameter int                ADDR_W    = 32,
  parameter int                RD_WAIT   = 1,
  parameter int                WR_WAIT   = 1,
  parameter logic [ADDR_W-1:0] FAST_BASE = 32'hbfd003f8,
  parameter logic [ADDR_W-1:0] FAST_MASK = 32'hfffffff8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_W-1:0]     mem_addr_i,
  input  logic [DATA_W-1:0]     mem_data_i,
  input  logic                  mem_we_n_i,
  input  logic                  mem_oe_n_i,
  input  logic                  mem_ce_n_i,
  input  logic [DATA_W/8-1:0]   mem_be_n_i,
  input  logic [DATA_W-1:0]     ram_data_i,
  output logic [DATA_W-1:0]     ram_data_o,
  output logic                  stall_from_mem,
  output logic [ADDR_W-1:0]     sram_addr_o,
  output logic [DATA_W-1:0]     sram_wdata_o,
  output logic [DATA_W/8-1:0]   sram_be_n_o,
  output logic                  sram_we_n_o,
  output logic                  sram_oe_n_o,
  output logic                  sram_ce_n_o
`ifdef MEM_WAIT_STATS_EN
  ,
  output logic [31:0]           stall_cnt_o,
  output logic [31:0]           acc_cnt_o
`endif
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [3:0] RD_LD = 4'(RD_WAIT - 1);
  localparam logic [3:0] WR_LD = 4'(WR_WAIT - 1);

  typedef struct packed {
    logic [ADDR_W-1:0]   addr;
    logic [DATA_W-1:0]   wdata;
    logic [DATA_W/8-1:0] be_n;
    logic                we_n;
    logic                oe_n;
  } cap_t;

  logic [1:0]        state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  cap_t              cap_q, cap_d, in_req;
  logic              req, fast, is_wr;
  logic [3:0]        load;

  assign req    = ~mem_ce_n_i & (~mem_oe_n_i | ~mem_we_n_i);
  assign fast   = (mem_addr_i & FAST_MASK) == (FAST_BASE & FAST_MASK);
  // A low write enable wins when both strobes are asserted.
  assign is_wr  = ~mem_we_n_i;
  assign load   = is_wr ? WR_LD : RD_LD;
  assign in_req = '{addr: mem_addr_i, wdata: mem_data_i, be_n: mem_be_n_i,
                    we_n: mem_we_n_i, oe_n: mem_oe_n_i};

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    cap_d          = cap_q;
    rdata_d        = rdata_q;
    stall_from_mem = 1'b0;
    ram_data_o     = '0;
    sram_addr_o    = mem_addr_i;
    sram_wdata_o   = mem_data_i;
    sram_be_n_o    = mem_be_n_i;
    sram_we_n_o    = 1'b1;
    sram_oe_n_o    = 1'b1;
    sram_ce_n_o    = 1'b1;
    case (state_q)
      S_IDLE: begin
        if (req) begin
          sram_we_n_o = mem_we_n_i;
          sram_oe_n_o = mem_oe_n_i;
          sram_ce_n_o = 1'b0;
          if (fast) begin
            ram_data_o = ram_data_i;
          end else begin
            cap_d          = in_req;
            cnt_d          = load;
            stall_from_mem = 1'b1;
            state_d        = (load == 4'd0) ? S_DONE : S_WAIT;
            if (load == 4'd0 && !is_wr) rdata_d = ram_data_i;
          end
        end
      end
      S_WAIT: begin
        sram_addr_o  = cap_q.addr;
        sram_wdata_o = cap_q.wdata;
        sram_be_n_o  = cap_q.be_n;
        if (mem_ce_n_i) begin
          // CPU withdrew the access: drop it without a completion cycle.
          state_d = S_IDLE;
          cnt_d   = 4'd0;
        end else begin
          stall_from_mem = 1'b1;
          sram_we_n_o    = cap_q.we_n;
          sram_oe_n_o    = cap_q.oe_n;
          sram_ce_n_o    = 1'b0;
          cnt_d          = cnt_q - 4'd1;
          if (cnt_q == 4'd1) begin
            state_d = S_DONE;
            if (cap_q.we_n) rdata_d = ram_data_i;
          end
        end
      end
      S_DONE: begin
        ram_data_o   = rdata_q;
        sram_addr_o  = cap_q.addr;
        sram_wdata_o = cap_q.wdata;
        sram_be_n_o  = cap_q.be_n;
        state_d      = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      rdata_q <= '0;
      cap_q   <= '{addr: '0, wdata: '0, be_n: '0, we_n: 1'b1, oe_n: 1'b1};
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      cap_q   <= cap_d;
    end
  end

`ifdef MEM_WAIT_STATS_EN
  logic [31:0] stall_cnt_q, acc_cnt_q;
  logic        acc_evt;

  assign acc_evt = (state_q == S_DONE) || (state_q == S_IDLE && req && fast);

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
      acc_cnt_q   <= '0;
    end else begin
      if (stall_from_mem && stall_cnt_q != '1) stall_cnt_q <= stall_cnt_q + 32'd1;
      if (acc_evt && acc_cnt_q != '1)          acc_cnt_q   <= acc_cnt_q + 32'd1;
    end
  end

  assign stall_cnt_o = stall_cnt_q;
  assign acc_cnt_o   = acc_cnt_q;
`endif

endmodule
